frame_bbox_extract: RTL

- Sits directly downstream of the 3x3 Gaussian-weighted filter stage and consumes its saturated 10-bit filtered pixel stream.
- Binarizes each pixel against a per-frame threshold and forwards the binary stream.
- Tracks raster position, accumulates the foreground bounding box and pixel count over one frame, and presents them at end of frame to the recognition logic.

---
 rtl/frame_bbox_extract_if.sv | 38 +++
 rtl/frame_bbox_extract.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/frame_bbox_extract_if.sv
// Pixel-stream and result bundle for frame_bbox_extract.
// master: the upstream filter side, which drives frame_start, per_clken,
//         pixel_data and threshold and observes every result.
// slave : frame_bbox_extract, which receives the stream and drives the binary
//         stream, the bounding-box results and the frame status.
interface frame_bbox_extract_if #(
  parameter int DATA_W = 10,
  parameter int COL_W  = 10,
  parameter int ROW_W  = 9,
  parameter int CNT_W  = 19
);
  logic              frame_start;
  logic              per_clken;
  logic [DATA_W-1:0] pixel_data;
  logic [DATA_W-1:0] threshold;
  logic              bin_valid;
  logic              bin_data;
  logic              bbox_valid;
  logic [COL_W-1:0]  x_min;
  logic [COL_W-1:0]  x_max;
  logic [ROW_W-1:0]  y_min;
  logic [ROW_W-1:0]  y_max;
  logic [CNT_W-1:0]  fg_count;
  logic              frame_empty;
  logic              frame_err;

  modport master (
    output frame_start, per_clken, pixel_data, threshold,
    input  bin_valid, bin_data, bbox_valid, x_min, x_max, y_min, y_max,
           fg_count, frame_empty, frame_err
  );

  modport slave (
    input  frame_start, per_clken, pixel_data, threshold,
    output bin_valid, bin_data, bbox_valid, x_min, x_max, y_min, y_max,
           fg_count, frame_empty, frame_err
  );
endinterface

// File: rtl/frame_bbox_extract.sv
// frame_bbox_extract: binarizes the filtered pixel stream against a per-frame
// threshold and accumulates the foreground bounding box and pixel count of each
// frame, presenting them with a one-cycle bbox_valid at end of frame.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   bus  - slave side of frame_bbox_extract_if:
//          in : frame_start, per_clken, pixel_data, threshold
//          out: bin_valid, bin_data (registered binary stream),
//               bbox_valid, x_min, x_max, y_min, y_max, fg_count, frame_empty
//               (end-of-frame results, held until the next frame completes),
//               frame_err (one-cycle pulse when a frame is aborted)
module frame_bbox_extract #(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int DATA_W = 10,
  parameter int COL_W  = 10,
  parameter int ROW_W  = 9,
  parameter int CNT_W  = 19
) (
  input  logic                  clk,
  input  logic                  rst,
  frame_bbox_extract_if.slave   bus
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  function automatic logic is_fg(input logic [DATA_W-1:0] pix,
                                 input logic [DATA_W-1:0] thr);
    return pix >= thr;
  endfunction

  state_t            state, state_nxt;
  logic [DATA_W-1:0] thr_lat;
  logic              fg_p0;
  logic              vld_p1;
  logic              bin_p1;
  logic              last_px;
  logic              acc_en;
  logic              err_q;

  logic [COL_W-1:0]  col, acc_x_min, acc_x_max, res_x_min, res_x_max;
  logic [ROW_W-1:0]  row, acc_y_min, acc_y_max, res_y_min, res_y_max;
  logic [CNT_W-1:0]  acc_cnt, res_cnt;
  logic              res_empty;

  assign fg_p0   = is_fg(bus.pixel_data, thr_lat);
  assign last_px = (col == COL_LAST) && (row == ROW_LAST);
  // A frame_start always opens a fresh frame, so a pixel on that same cycle is
  // never accumulated (neither on a clean start nor on an abort).
  assign acc_en  = (state == ACTIVE) && bus.per_clken && !bus.frame_start;

  // Stage p0 -> p1: registered binarization, independent of the FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      bin_p1 <= 1'b0;
    end else begin
      vld_p1 <= bus.per_clken;
      if (bus.per_clken) bin_p1 <= fg_p0;
    end
  end

  // The pulse's own cycle still compares against the previous threshold.
  always_ff @(posedge clk) begin
    if (rst)                  thr_lat <= '0;
    else if (bus.frame_start) thr_lat <= bus.threshold;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.frame_start) state_nxt = ACTIVE;
      ACTIVE:  if (bus.frame_start) state_nxt = ACTIVE;
               else if (bus.per_clken && last_px) state_nxt = DONE;
      DONE:    state_nxt = bus.frame_start ? ACTIVE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Raster position and accumulators
  always_ff @(posedge clk) begin
    if (rst || bus.frame_start) begin
      col       <= '0;
      row       <= '0;
      acc_x_min <= '0;
      acc_x_max <= '0;
      acc_y_min <= '0;
      acc_y_max <= '0;
      acc_cnt   <= '0;
    end else if (acc_en) begin
      if (fg_p0) begin
        acc_cnt <= acc_cnt + 1'b1;
        if (acc_cnt == '0) begin
          acc_x_min <= col;
          acc_x_max <= col;
          acc_y_min <= row;
          acc_y_max <= row;
        end else begin
          if (col < acc_x_min) acc_x_min <= col;
          if (col > acc_x_max) acc_x_max <= col;
          // Raster order makes the current row the largest seen so far.
          acc_y_max <= row;
        end
      end
      if (col == COL_LAST) begin
        col <= '0;
        row <= last_px ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Results are captured on the DONE cycle; the accumulators still hold the
  // completed frame then, even if a new frame_start clears them on that edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_x_min <= '0;
      res_x_max <= '0;
      res_y_min <= '0;
      res_y_max <= '0;
      res_cnt   <= '0;
      res_empty <= 1'b0;
    end else if (state == DONE) begin
      res_x_min <= acc_x_min;
      res_x_max <= acc_x_max;
      res_y_min <= acc_y_min;
      res_y_max <= acc_y_max;
      res_cnt   <= acc_cnt;
      res_empty <= (acc_cnt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= (state == ACTIVE) && bus.frame_start;
  end

  // During DONE the live accumulators are shown so bbox_valid and its results
  // appear together one cycle after the last pixel; afterwards the held copy.
  always_comb begin
    bus.bbox_valid  = 1'b0;
    bus.x_min       = res_x_min;
    bus.x_max       = res_x_max;
    bus.y_min       = res_y_min;
    bus.y_max       = res_y_max;
    bus.fg_count    = res_cnt;
    bus.frame_empty = res_empty;
    if (state == DONE) begin
      bus.bbox_valid  = 1'b1;
      bus.x_min       = acc_x_min;
      bus.x_max       = acc_x_max;
      bus.y_min       = acc_y_min;
      bus.y_max       = acc_y_max;
      bus.fg_count    = acc_cnt;
      bus.frame_empty = (acc_cnt == '0);
    end
  end

  assign bus.bin_valid = vld_p1;
  assign bus.bin_data  = bin_p1;
  assign bus.frame_err = err_q;

endmodule
